// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the sequential multiplier controller.
// State encoding and derived width helper.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        ADD,
        SHIFT,
        DONE
    } state_t;

    function automatic int ctrl_cw(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_seq_control_if.sv
// Handshake and datapath-strobe bundle of the multiplier controller.
// The controller side uses the slave modport.
interface mult_seq_control_if #(
    parameter int WIDTH = 8
);
    import mult_ctrl_pkg::*;

    localparam int CW = ctrl_cw(WIDTH);

    logic          Load_B;
    logic          Run;
    logic          M;
    logic          Signed_Mode;
    logic          Clr_XA;
    logic          Ld_B;
    logic          Add;
    logic          Sub;
    logic          Shift;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Bit_Idx;

    modport master (
        output Load_B, Run, M, Signed_Mode,
        input  Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done, Bit_Idx
    );

    modport slave (
        input  Load_B, Run, M, Signed_Mode,
        output Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done, Bit_Idx
    );

endinterface

// File: rtl/bit_counter.sv
// Iteration counter for the add/shift loop.
// Saturates at WIDTH-1; 'last' flags the final iteration.
module bit_counter
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = ctrl_cw(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          clr,
    input  logic          inc,
    output logic          last,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == LAST_IDX);
    assign cnt  = cnt_q;

    // Next count: clear wins, otherwise step until the last index.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mult_seq_control.sv
// Control FSM for the add-shift multiplier datapath.
// Counter-based loop of ADD/SHIFT pairs, one pair per operand bit.
module mult_seq_control
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = ctrl_cw(WIDTH)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mult_seq_control_if.slave bus
);

    state_t        state_q;
    state_t        state_d;
    logic          sgn_q;
    logic          sgn_d;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic [CW-1:0] cnt;

    logic          clr_xa;
    logic          ld_b;
    logic          add;
    logic          sub;
    logic          shift;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_idx;

    assign cnt_clr = (state_q == CLEAR);
    assign cnt_inc = (state_q == SHIFT);

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (cnt_last),
        .cnt     (cnt)
    );

    // Next-state logic; sign mode is latched only when a run starts.
    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Load_B) begin
                    state_d = LOAD;
                end else if (bus.Run) begin
                    state_d = CLEAR;
                    sgn_d   = bus.Signed_Mode;
                end
            end
            LOAD:    state_d = IDLE;
            CLEAR:   state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = cnt_last ? DONE : ADD;
            DONE:    state_d = bus.Run ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state strobes; the top bit subtracts in signed mode.
    always_comb begin
        clr_xa  = 1'b0;
        ld_b    = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        bit_idx = '0;
        unique case (state_q)
            LOAD: begin
                ld_b   = 1'b1;
                clr_xa = 1'b1;
            end
            CLEAR: begin
                clr_xa = 1'b1;
                busy   = 1'b1;
            end
            ADD: begin
                busy    = 1'b1;
                add     = bus.M & ~(sgn_q & cnt_last);
                sub     = bus.M & sgn_q & cnt_last;
                bit_idx = cnt;
            end
            SHIFT: begin
                shift   = 1'b1;
                busy    = 1'b1;
                bit_idx = cnt;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // State and sign-mode registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
        end
    end

    assign bus.Clr_XA  = clr_xa;
    assign bus.Ld_B    = ld_b;
    assign bus.Add     = add;
    assign bus.Sub     = sub;
    assign bus.Shift   = shift;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Bit_Idx = bit_idx;

endmodule

// File: tb/tb_mult_seq_control.sv
// Randomized bench for mult_seq_control against a timeline model.
// Two instances: WIDTH=8 (a) and WIDTH=4 (b).
module tb_mult_seq_control;

    typedef logic [10:0] ov_t;

    localparam ov_t ZERO   = 11'b000_0000_0000;
    localparam ov_t DONE_V = 11'b000_0001_0000;
    localparam ov_t CLR_V  = 11'b100_0010_0000;
    localparam ov_t LOAD_V = 11'b110_0000_0000;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    ov_t  exp_q[$];

    mult_seq_control_if #(.WIDTH(8)) ia ();
    mult_seq_control_if #(.WIDTH(4)) ib ();

    mult_seq_control #(.WIDTH(8)) dut_a (
        .Clk     (clk),
        .Reset_n (rst_a),
        .bus     (ia.slave)
    );

    mult_seq_control #(.WIDTH(4)) dut_b (
        .Clk     (clk),
        .Reset_n (rst_b),
        .bus     (ib.slave)
    );

    always #5 clk = ~clk;

    function automatic ov_t pk(logic clr, logic ld, logic ad, logic sb,
                               logic sh, logic bs, logic dn,
                               logic [3:0] idx);
        return {clr, ld, ad, sb, sh, bs, dn, idx};
    endfunction

    function automatic ov_t obs_a();
        return pk(ia.Clr_XA, ia.Ld_B, ia.Add, ia.Sub, ia.Shift,
                  ia.Busy, ia.Done, {1'b0, ia.Bit_Idx});
    endfunction

    function automatic ov_t obs_b();
        return pk(ib.Clr_XA, ib.Ld_B, ib.Add, ib.Sub, ib.Shift,
                  ib.Busy, ib.Done, {2'b00, ib.Bit_Idx});
    endfunction

    // Expected output per cycle from the CLEAR cycle to the first DONE cycle.
    function automatic void build_trace(int w, bit sgn, logic [7:0] mb);
        exp_q.delete();
        exp_q.push_back(CLR_V);
        for (int i = 0; i < w; i++) begin
            bit top;
            bit ad;
            bit sb;
            top = (i == w - 1);
            ad  = mb[i] && !(sgn && top);
            sb  = mb[i] && sgn && top;
            exp_q.push_back(pk(0, 0, ad, sb, 0, 1, 0, 4'(i)));
            exp_q.push_back(pk(0, 0, 0, 0, 1, 1, 0, 4'(i)));
        end
        exp_q.push_back(DONE_V);
    endfunction

    task automatic wait_done_a(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ia.Done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_done_b(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ib.Done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_a          = 1'b0;
        ia.Run         = 1'b1;
        ia.Load_B      = 1'b0;
        ia.M           = 1'b0;
        ia.Signed_Mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_a() !== ZERO) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, obs_a(), ZERO);
            end
        end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== CLR_V) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs_a(), CLR_V);
        end
        wait_done_a(n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL reset_run_latency got %0d want 17", n);
        end
        ia.Run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== ZERO) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", obs_a(), ZERO);
        end
    endtask

    // One full multiply on instance a; control inputs are scrambled while busy.
    task automatic test_multiply(input bit sgn, input logic [7:0] mb,
                                 output int n_add, output int n_sub,
                                 output int n_sh);
        build_trace(8, sgn, mb);
        n_add          = 0;
        n_sub          = 0;
        n_sh           = 0;
        ia.Run         = 1'b1;
        ia.Load_B      = 1'b0;
        ia.Signed_Mode = sgn;
        ia.M           = 1'($urandom);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_a() !== exp_q[c]) begin
                errors++;
                $display("FAIL mult cyc %0d sgn %0d mb %h got %h want %h",
                         c, sgn, mb, obs_a(), exp_q[c]);
            end
            if (ia.Add === 1'b1) n_add++;
            if (ia.Sub === 1'b1) n_sub++;
            if (ia.Shift === 1'b1) n_sh++;
            if ((c % 2) == 0 && c < 16) begin
                ia.M = mb[c / 2];
            end else begin
                ia.M = 1'($urandom);
            end
            ia.Run         = (c == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
            ia.Load_B      = 1'($urandom);
            ia.Signed_Mode = 1'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== ZERO) begin
            errors++;
            $display("FAIL mult_release got %h want %h", obs_a(), ZERO);
        end
        ia.Load_B = 1'b0;
        ia.Run    = 1'b0;
    endtask

    task automatic test_unsigned();
        int na, ns, nh;
        test_multiply(1'b0, 8'hFF, na, ns, nh);
        checks++;
        if (na !== 8 || ns !== 0 || nh !== 8) begin
            errors++;
            $display("FAIL unsigned_counts got add %0d sub %0d shift %0d want 8 0 8",
                     na, ns, nh);
        end
    endtask

    task automatic test_signed();
        int na, ns, nh;
        test_multiply(1'b1, 8'b1000_0001, na, ns, nh);
        checks++;
        if (na !== 1 || ns !== 1 || nh !== 8) begin
            errors++;
            $display("FAIL signed_counts got add %0d sub %0d shift %0d want 1 1 8",
                     na, ns, nh);
        end
    endtask

    task automatic test_random();
        int na, ns, nh, ea, es;
        bit sgn;
        logic [7:0] mb;
        for (int r = 0; r < 6; r++) begin
            sgn = 1'($urandom);
            mb  = 8'($urandom);
            es  = (sgn && mb[7]) ? 1 : 0;
            ea  = $countones(mb) - es;
            test_multiply(sgn, mb, na, ns, nh);
            checks++;
            if (na !== ea || ns !== es || nh !== 8) begin
                errors++;
                $display("FAIL random_counts r %0d got %0d %0d %0d want %0d %0d 8",
                         r, na, ns, nh, ea, es);
            end
        end
    endtask

    task automatic test_run_hold();
        int n;
        ia.Run         = 1'b1;
        ia.Load_B      = 1'b0;
        ia.Signed_Mode = 1'b0;
        wait_done_a(n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL hold_latency got %0d want 18", n);
        end
        for (int i = 0; i < 5; i++) begin
            ia.Load_B = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_a() !== DONE_V) begin
                errors++;
                $display("FAIL hold_done cyc %0d got %h want %h", i, obs_a(), DONE_V);
            end
        end
        ia.Run    = 1'b0;
        ia.Load_B = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== ZERO) begin
            errors++;
            $display("FAIL hold_release got %h want %h", obs_a(), ZERO);
        end
    endtask

    task automatic test_load_priority();
        int n;
        ia.Load_B = 1'b1;
        ia.Run    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== LOAD_V) begin
            errors++;
            $display("FAIL load_cycle got %h want %h", obs_a(), LOAD_V);
        end
        ia.Load_B = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== ZERO) begin
            errors++;
            $display("FAIL load_idle got %h want %h", obs_a(), ZERO);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== CLR_V) begin
            errors++;
            $display("FAIL load_then_clear got %h want %h", obs_a(), CLR_V);
        end
        ia.Run = 1'b0;
        wait_done_a(n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL load_run_latency got %0d want 17", n);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a() !== ZERO) begin
            errors++;
            $display("FAIL load_final_idle got %h want %h", obs_a(), ZERO);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        ib.M           = 1'($urandom);
        ib.Load_B      = 1'b0;
        ib.Signed_Mode = 1'b0;
        rst_b          = 1'b1;
        ib.Run         = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (obs_b() !== CLR_V) begin
                    errors++;
                    $display("FAIL w4_clear got %h want %h", obs_b(), CLR_V);
                end
            end
        end
        checks++;
        if (obs_b() !== pk(0, 0, 0, 0, 1, 1, 0, 4'd2)) begin
            errors++;
            $display("FAIL w4_shift2 got %h want %h", obs_b(),
                     pk(0, 0, 0, 0, 1, 1, 0, 4'd2));
        end
        rst_b  = 1'b0;
        ib.Run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_b() !== ZERO) begin
            errors++;
            $display("FAIL w4_abort got %h want %h", obs_b(), ZERO);
        end
        rst_b  = 1'b1;
        ib.Run = 1'b1;
        wait_done_b(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL w4_latency got %0d want 10", n);
        end
        ib.Run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_b() !== ZERO) begin
            errors++;
            $display("FAIL w4_idle got %h want %h", obs_b(), ZERO);
        end
    endtask

    initial begin
        rst_a          = 1'b0;
        rst_b          = 1'b0;
        ib.Run         = 1'b0;
        ib.Load_B      = 1'b0;
        ib.M           = 1'b0;
        ib.Signed_Mode = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_run_hold();
        test_load_priority();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_control.md
Name: mult_seq_control

Overview:
- Parametrised control FSM for the sequential add-shift multiplier datapath (X/A accumulator, B multiplier register).
- Replaces the fixed 8-bit, unrolled-state controller with a counter-based FSM of generic width.
- Adds a runtime signed/unsigned mode, explicit Busy/Done status and a Run release handshake.
- Issues one-hot-style datapath strobes. The datapath supplies M, the current LSB of B.

Parameters:
- WIDTH, 8, operand width in bits (number of add/shift iterations). Legal range is WIDTH >= 2.
- CW, $clog2(WIDTH), width of the Bit_Idx output. Derived value; not to be overridden.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset, sampled on the rising edge of Clk.
- Load_B  in  1  level request: load B from switches and clear X/A.
- Run  in  1  level request: start a multiply.
- M  in  1  current LSB of B, from the datapath register.
- Signed_Mode  in  1  1 selects two's-complement multiply (subtract on the last bit).
- Clr_XA  out  1  clear X and A registers.
- Ld_B  out  1  load the B register.
- Add  out  1  A <= A + S this cycle.
- Sub  out  1  A <= A - S this cycle.
- Shift  out  1  arithmetic right shift of X:A:B.
- Busy  out  1  multiply in progress.
- Done  out  1  result valid; held until Run is released.
- Bit_Idx  out  CW  index of the current iteration, 0..WIDTH-1.

Behaviour:
- States: IDLE, LOAD, CLEAR, ADD, SHIFT, DONE.
  - Only ADD and SHIFT repeat; there is no per-bit state.
  - The state register and cnt are updated on posedge Clk.
- Reset:
  - If Reset_n=0 at posedge Clk: state <= IDLE, cnt <= 0, sgn_q <= 0.
  - All outputs are 0 in the cycle after reset. Bit_Idx=0.
  - Reset mid-operation aborts the multiply immediately, with no extra cycles.
- IDLE:
  - Load_B=1 -> LOAD. Load_B has priority over Run.
  - Else Run=1 -> CLEAR; sgn_q <= Signed_Mode.
  - Else stay in IDLE.
- LOAD: Ld_B=1, Clr_XA=1 for one cycle, then -> IDLE.
- CLEAR: Clr_XA=1, Busy=1, cnt <= 0, then -> ADD.
- ADD:
  - Busy=1.
  - Add = M & ~(sgn_q & cnt==WIDTH-1).
  - Sub = M & sgn_q & (cnt==WIDTH-1).
  - Add and Sub are combinational on M and are never both 1.
  - Next state is always SHIFT.
- SHIFT:
  - Shift=1, Busy=1.
  - If cnt==WIDTH-1 -> DONE; else cnt <= cnt+1 and -> ADD.
- DONE:
  - Done=1.
  - Run=1 -> stay in DONE (no auto-restart).
  - Run=0 -> IDLE.
  - Load_B is ignored while in DONE.
- Latency:
  - Run is sampled high at edge k. CLEAR occupies cycle k+1.
  - Bit i: ADD in cycle k+2+2i, SHIFT in cycle k+3+2i.
  - DONE is first asserted in cycle k+2+2*WIDTH. For WIDTH=8 that is cycle k+18.
  - Timing is fixed and independent of M.
- Bit_Idx = cnt. It is valid during ADD and SHIFT, and is 0 in all other states.
- Run or Load_B changes while Busy=1 are ignored; the multiply always completes.
- Signed_Mode is sampled only at the IDLE->CLEAR edge. Changes during the operation have no effect.
- Only the outputs listed per state are 1; every other output is 0 in that state.

Decomposition:
- Package mult_ctrl_pkg:
  - typedef enum logic [2:0] state_t {IDLE, LOAD, CLEAR, ADD, SHIFT, DONE}.
  - Function ctrl_cw(width) returning $clog2(width).
- The iteration counter is a natural sub-module: bit_counter, with parameter WIDTH and ports Clk, Reset_n, clr, inc, last, cnt.
- All other logic stays in a single FSM module.

Test Plan:
1. Hold Reset_n=0 for 2 cycles with Run=1, then release -> outputs all 0 during reset. CLEAR (Clr_XA=1, Busy=1) appears the cycle after release.
2. WIDTH=8, Signed_Mode=0, M=1 on every ADD -> exactly 8 Add pulses and 0 Sub. 8 Shift pulses, on Bit_Idx 0..7. Done=1 in cycle k+18.
3. WIDTH=8, Signed_Mode=1, M pattern 1,0,0,0,0,0,0,1 -> Add once at Bit_Idx 0. Sub once at Bit_Idx 7, in cycle k+16. Add=0 in that cycle.
4. Run held 1 for 5 cycles after Done rises -> Done stays 1, no CLEAR. Drop Run -> IDLE next cycle, Done=0.
5. Load_B=1 and Run=1 together in IDLE -> one LOAD cycle (Ld_B=1, Clr_XA=1), then IDLE. Run still 1 -> CLEAR the cycle after that.
6. WIDTH=4 instance: Reset_n=0 at Bit_Idx 2 during SHIFT -> IDLE and all outputs 0 the next cycle. A fresh Run then completes with Done in cycle k+10.
